// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision adder that time-shares one 16-bit lookahead adder across WORDS limbs, LSB first.
// Define MPADD_SUB_EN to add the op_sub port and A-B support (B limbs inverted, initial carry 1).
module lac_unit (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co
);
   logic [15:0] g, p, c;
   logic [3:0]  gg, gp;
   logic [4:0]  gc;
   assign g = x & y;
   assign p = x ^ y;
   for (genvar j = 0; j < 4; j++) begin : grp
      localparam int lo = 4 * j;
      assign gg[j] = g[lo+3] | (p[lo+3] & g[lo+2]) | (p[lo+3] & p[lo+2] & g[lo+1])
                   | (p[lo+3] & p[lo+2] & p[lo+1] & g[lo]);
      assign gp[j] = &p[lo +: 4];
      assign c[lo]   = gc[j];
      assign c[lo+1] = g[lo] | (p[lo] & gc[j]);
      assign c[lo+2] = g[lo+1] | (p[lo+1] & g[lo]) | (p[lo+1] & p[lo] & gc[j]);
      assign c[lo+3] = g[lo+2] | (p[lo+2] & g[lo+1]) | (p[lo+2] & p[lo+1] & g[lo])
                     | (p[lo+2] & p[lo+1] & p[lo] & gc[j]);
   end
   // second lookahead level across the four 4-bit groups
   assign gc[0] = ci;
   assign gc[1] = gg[0] | (gp[0] & ci);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
   assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
   assign s  = p ^ c;
   assign co = gc[4];
endmodule

module mp_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
`ifdef MPADD_SUB_EN
   input  logic                  op_sub,
`endif
   input  logic [16*WORDS-1:0]   a,
   input  logic [16*WORDS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [16*WORDS-1:0]   sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  zero
);
   localparam int CW = $clog2(WORDS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t              state;
   logic [16*WORDS-1:0] a_r, b_r;
   logic [CW-1:0]       cnt;
   logic                carry;
   logic [15:0]         a_l, b_l, b_e, s;
   logic                co, init_c, last;
`ifdef MPADD_SUB_EN
   logic                op_r;
   assign b_e    = op_r ? ~b_l : b_l;
   assign init_c = op_sub;
`else
   assign b_e    = b_l;
   assign init_c = 1'b0;
`endif
   assign a_l  = a_r[{cnt, 4'd0} +: 16];
   assign b_l  = b_r[{cnt, 4'd0} +: 16];
   assign last = cnt == CW'(WORDS - 1);
   assign zero = sum == '0;
   lac_unit u_lac (
      .x  (a_l),
      .y  (b_e),
      .ci (carry),
      .s  (s),
      .co (co)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
`ifdef MPADD_SUB_EN
         op_r  <= 1'b0;
`endif
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r   <= a;
               b_r   <= b;
`ifdef MPADD_SUB_EN
               op_r  <= op_sub;
`endif
               cnt   <= '0;
               carry <= init_c;
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               sum[{cnt, 4'd0} +: 16] <= s;
               carry <= co;
               if (last) begin
                  cout  <= co;
                  ovf   <= (a_l[15] == b_e[15]) && (s[15] != a_l[15]);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
